// File: rtl/fault_fsm_nch_pkg.sv
// Shared definitions for the N-channel fault escalation block:
// state encodings, fault id width and packed counter-bus slicing.
package fault_pkg;

    // Escalation levels. The encoding is visible on the state port.
    typedef enum logic [1:0] {
        S_NORMAL   = 2'b00,
        S_WARNING  = 2'b01,
        S_FAULT    = 2'b10,
        S_SHUTDOWN = 2'b11
    } state_e;

    // Width of channel ids (index+1, 0 = none); covers up to 15 channels.
    localparam int FAULT_ID_W = 4;

    // Low bit of channel ch inside a packed bus of w-bit slices.
    function automatic int cnt_lo(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

// File: rtl/fault_chan_cnt.sv
// Saturating leaky persistence counter for one fault channel.
// Counts up while act is high (sticks at all-ones), and while act is low
// decays by LEAK per cycle down to zero. LEAK=0 clears at once.
module fault_chan_cnt #(
    parameter int CNT_W = 8,
    parameter int LEAK  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             act,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // Only used when cnt_q >= LEAK, which implies LEAK fits in CNT_W bits.
    localparam logic [CNT_W-1:0] LEAK_V  = CNT_W'(LEAK);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: saturating increment when active, floored decay otherwise.
    always_comb begin
        cnt_d = cnt_q;
        if (act) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (LEAK == 0) begin
            cnt_d = '0;
        end else if (int'(cnt_q) >= LEAK) begin
            cnt_d = cnt_q - LEAK_V;
        end else begin
            cnt_d = '0;
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/fault_fsm_nch.sv
// N-channel fault escalation FSM (NORMAL/WARNING/FAULT/SHUTDOWN).
// Each unmasked fault flag drives a leaky persistence counter; the FSM
// escalates one level per cycle when any active channel's registered count
// has reached the next threshold. SHUTDOWN only leaves on reset.
// Optional macro FAULT_LOG_EN enables first_fault_id / sticky logging;
// without it those ports read 0.
// There is no valid/ready handshake here: every input is level-sampled on
// each rising clk edge and every output is valid continuously.
module fault_fsm_nch
    import fault_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 8,
    parameter int P_WARN  = 5,
    parameter int P_FAULT = 12,
    parameter int P_SHUT  = 30,
    parameter int LEAK    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       flt_in,
    input  logic [N_CH-1:0]       mask,
    input  logic                  clear_warning,
    output logic [1:0]            state,
    output logic                  warn,
    output logic                  fault,
    output logic                  shutdown,
    output logic [3:0]            active_fault_id,
    output logic [N_CH*CNT_W-1:0] cnt_bus,
    output logic [3:0]            first_fault_id,
    output logic [N_CH-1:0]       sticky
);

    // Parameter sanity: thresholds strictly ordered and representable.
    if (!(P_WARN > 0 && P_WARN < P_FAULT && P_FAULT < P_SHUT &&
          P_SHUT <= (2 ** CNT_W) - 1 && N_CH >= 1 && N_CH <= 15)) begin : g_bad_params
        $error("fault_fsm_nch: illegal parameter set");
    end

    logic [N_CH-1:0]       act;
    logic [CNT_W-1:0]      cnt_w [N_CH];
    logic [N_CH-1:0]       at_warn;
    logic [N_CH-1:0]       at_fault;
    logic [N_CH-1:0]       at_shut;
    logic                  req_warn;
    logic                  req_fault;
    logic                  req_shut;
    logic                  any_act;
    logic [FAULT_ID_W-1:0] id_w;

    state_e state_d;
    state_e state_q;
    logic   warn_q;
    logic   fault_q;
    logic   shut_q;

    assign act     = flt_in & ~mask;
    assign any_act = |act;

    // One persistence counter per channel.
    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        fault_chan_cnt #(
            .CNT_W (CNT_W),
            .LEAK  (LEAK)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .act   (act[i]),
            .cnt   (cnt_w[i])
        );
        assign cnt_bus[cnt_lo(i, CNT_W) +: CNT_W] = cnt_w[i];
        assign at_warn[i]  = act[i] && (int'(cnt_w[i]) >= P_WARN);
        assign at_fault[i] = act[i] && (int'(cnt_w[i]) >= P_FAULT);
        assign at_shut[i]  = act[i] && (int'(cnt_w[i]) >= P_SHUT);
    end

    assign req_warn  = |at_warn;
    assign req_fault = |at_fault;
    assign req_shut  = |at_shut;

    // Priority encoder: the highest active channel index wins; id = index+1.
    always_comb begin
        id_w = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (act[i]) begin
                id_w = FAULT_ID_W'(i + 1);
            end
        end
    end

    assign active_fault_id = id_w;

    // Next state: at most one escalation step per cycle; clear only when idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_NORMAL: begin
                if (req_warn) begin
                    state_d = S_WARNING;
                end
            end
            S_WARNING: begin
                if (req_fault) begin
                    state_d = S_FAULT;
                end else if (!any_act && clear_warning) begin
                    state_d = S_NORMAL;
                end
            end
            S_FAULT: begin
                if (req_shut) begin
                    state_d = S_SHUTDOWN;
                end else if (!any_act && clear_warning) begin
                    state_d = S_NORMAL;
                end
            end
            S_SHUTDOWN: begin
                state_d = S_SHUTDOWN;
            end
            default: begin
                state_d = S_NORMAL;
            end
        endcase
    end

    // State register with registered one-hot style decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_NORMAL;
            warn_q  <= 1'b0;
            fault_q <= 1'b0;
            shut_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            warn_q  <= (state_d == S_WARNING);
            fault_q <= (state_d == S_FAULT);
            shut_q  <= (state_d == S_SHUTDOWN);
        end
    end

    assign state    = state_q;
    assign warn     = warn_q;
    assign fault    = fault_q;
    assign shutdown = shut_q;

`ifdef FAULT_LOG_EN
    logic                  clear_evt;
    logic [FAULT_ID_W-1:0] first_d;
    logic [FAULT_ID_W-1:0] first_q;
    logic [N_CH-1:0]       sticky_d;
    logic [N_CH-1:0]       sticky_q;

    // An operator clear that actually returns the FSM to NORMAL.
    assign clear_evt = (state_q == S_WARNING || state_q == S_FAULT) &&
                       (state_d == S_NORMAL);

    // Log next values: capture the id on the first warning, accumulate
    // channels that crossed P_WARN, wipe both on an effective clear.
    always_comb begin
        first_d  = first_q;
        sticky_d = sticky_q | at_warn;
        if (state_q == S_NORMAL && state_d == S_WARNING) begin
            first_d = id_w;
        end
        if (clear_evt) begin
            first_d  = '0;
            sticky_d = '0;
        end
    end

    // Log registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q  <= '0;
            sticky_q <= '0;
        end else begin
            first_q  <= first_d;
            sticky_q <= sticky_d;
        end
    end

    assign first_fault_id = first_q;
    assign sticky         = sticky_q;
`else
    assign first_fault_id = '0;
    assign sticky         = '0;
`endif

endmodule

// File: tb/tb_fault_fsm_nch.sv
// Bench for fault_fsm_nch: two instances (default parameters, and a narrow
// 4-bit counter / LEAK=2 build) share randomised phased stimulus. A driver
// pushes model predictions into exp_q; a monitor pops and compares.
module tb_fault_fsm_nch;

  localparam int N = 4;

  typedef struct packed {
    logic [1:0][1:0]  st;
    logic [1:0][3:0]  id;
    logic [1:0][31:0] cnt;
    logic [1:0][3:0]  first;
    logic [1:0][3:0]  stk;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] flt_in = '0;
  logic [N-1:0] mask = '0;
  logic clear_warning = 1'b0;

  logic [1:0] state_a, state_b;
  logic warn_a, fault_a, shut_a, warn_b, fault_b, shut_b;
  logic [3:0] id_a, id_b, first_a, first_b;
  logic [N*8-1:0] cnt_a;
  logic [N*4-1:0] cnt_b;
  logic [N-1:0] stk_a, stk_b;

  int total = 0;
  int bad = 0;
  exp_t exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fault_fsm_nch #(.N_CH(N)) u_a (
    .clk(clk), .rst_n(rst_n), .flt_in(flt_in), .mask(mask),
    .clear_warning(clear_warning), .state(state_a), .warn(warn_a),
    .fault(fault_a), .shutdown(shut_a), .active_fault_id(id_a),
    .cnt_bus(cnt_a), .first_fault_id(first_a), .sticky(stk_a)
  );

  fault_fsm_nch #(.N_CH(N), .CNT_W(4), .P_WARN(3), .P_FAULT(7), .P_SHUT(15), .LEAK(2)) u_b (
    .clk(clk), .rst_n(rst_n), .flt_in(flt_in), .mask(mask),
    .clear_warning(clear_warning), .state(state_b), .warn(warn_b),
    .fault(fault_b), .shutdown(shut_b), .active_fault_id(id_b),
    .cnt_bus(cnt_b), .first_fault_id(first_b), .sticky(stk_b)
  );

  // ---------------- reference model ----------------
  // Level 0..3 = NORMAL..SHUTDOWN; thr[k][l] is the count requesting level l.
  int m_cnt[2][N];
  int m_lvl[2];
  int m_first[2];
  logic [N-1:0] m_stk[2];
  int thr[2][4];
  int cmax[2];
  int leak[2];
  int cw[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_lvl[k] = 0;
      m_first[k] = 0;
      m_stk[k] = '0;
      for (int i = 0; i < N; i++) m_cnt[k][i] = 0;
    end
  endtask

  task automatic model_step(input logic [N-1:0] f, input logic [N-1:0] m, input logic clr, output exp_t e);
    logic [N-1:0] a;
    int id;
    int nxt;
    bit up;
    a = f & ~m;
    id = 0;
    for (int i = 0; i < N; i++) if (a[i]) id = i + 1;
    e = '0;
    for (int k = 0; k < 2; k++) begin
      logic [31:0] v;
      nxt = m_lvl[k];
      up = 0;
      if (m_lvl[k] < 3)
        for (int i = 0; i < N; i++) if (a[i] && m_cnt[k][i] >= thr[k][m_lvl[k] + 1]) up = 1;
      if (up) nxt = m_lvl[k] + 1;
      else if ((m_lvl[k] == 1 || m_lvl[k] == 2) && a == '0 && clr) nxt = 0;
`ifdef FAULT_LOG_EN
      for (int i = 0; i < N; i++) if (a[i] && m_cnt[k][i] >= thr[k][1]) m_stk[k][i] = 1'b1;
      if (m_lvl[k] == 0 && nxt == 1) m_first[k] = id;
      if (m_lvl[k] != 0 && nxt == 0) begin
        m_first[k] = 0;
        m_stk[k] = '0;
      end
`endif
      m_lvl[k] = nxt;
      v = '0;
      for (int i = 0; i < N; i++) begin
        if (a[i]) m_cnt[k][i] = (m_cnt[k][i] + 1 > cmax[k]) ? cmax[k] : m_cnt[k][i] + 1;
        else if (leak[k] == 0) m_cnt[k][i] = 0;
        else m_cnt[k][i] = (m_cnt[k][i] - leak[k] < 0) ? 0 : m_cnt[k][i] - leak[k];
        v = v | (32'(m_cnt[k][i]) << (i * cw[k]));
      end
      e.st[k] = 2'(m_lvl[k]);
      e.id[k] = 4'(id);
      e.cnt[k] = v;
      e.first[k] = 4'(m_first[k]);
      e.stk[k] = m_stk[k];
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s inst%0d got=%h want=%h t=%0t", name, k, got, want, $time);
    end
  endtask

  task automatic compare_inst(input int k, input exp_t e);
    logic [1:0] st;
    logic w, f, s;
    logic [3:0] id, fi;
    logic [31:0] c;
    logic [N-1:0] sk;
    if (k == 0) begin
      st = state_a; w = warn_a; f = fault_a; s = shut_a; id = id_a;
      c = 32'(cnt_a); fi = first_a; sk = stk_a;
    end else begin
      st = state_b; w = warn_b; f = fault_b; s = shut_b; id = id_b;
      c = 32'(cnt_b); fi = first_b; sk = stk_b;
    end
    chk("state", k, 32'(st), 32'(e.st[k]));
    chk("warn", k, 32'(w), 32'(e.st[k] == 2'd1));
    chk("fault", k, 32'(f), 32'(e.st[k] == 2'd2));
    chk("shutdown", k, 32'(s), 32'(e.st[k] == 2'd3));
    chk("active_id", k, 32'(id), 32'(e.id[k]));
    chk("cnt_bus", k, c, e.cnt[k]);
    chk("first_id", k, 32'(fi), 32'(e.first[k]));
    chk("sticky", k, 32'(sk), 32'(e.stk[k]));
  endtask

  // Monitor: one prediction per rising edge, sampled 1 ns later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare_inst(0, e);
        compare_inst(1, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input logic [N-1:0] f, input logic [N-1:0] m, input logic clr);
    exp_t e;
    @(negedge clk);
    flt_in = f;
    mask = m;
    clear_warning = clr;
    model_step(f, m, clr, e);
    exp_q.push_back(e);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    flt_in = '0;
    mask = '0;
    clear_warning = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_state", 0, 32'(state_a), 32'd0);
    chk("rst_state", 1, 32'(state_b), 32'd0);
    chk("rst_cnt", 0, 32'(cnt_a), 32'd0);
    chk("rst_cnt", 1, 32'(cnt_b), 32'd0);
    chk("rst_flags", 0, 32'({warn_a, fault_a, shut_a}), 32'd0);
    chk("rst_log", 0, 32'({first_a, stk_a}), 32'd0);
    chk("rst_log", 1, 32'({first_b, stk_b}), 32'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
    model_step('0, '0, 1'b0, e);
    exp_q.push_back(e);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int kind, len, ch;
    logic [N-1:0] hot, f, m;
    logic clr;
    cw[0] = 8; cmax[0] = 255; leak[0] = 1;
    thr[0][0] = 0; thr[0][1] = 5; thr[0][2] = 12; thr[0][3] = 30;
    cw[1] = 4; cmax[1] = 15; leak[1] = 2;
    thr[1][0] = 0; thr[1][1] = 3; thr[1][2] = 7; thr[1][3] = 15;
    model_reset();
    do_reset();

    // Directed opener: ch0 for 6 cycles, then quiet with a clear.
    for (int c = 0; c < 6; c++) drive_cycle(4'b0001, '0, 1'b0);
    drive_cycle(4'b0000, '0, 1'b1);
    for (int c = 0; c < 10; c++) drive_cycle('0, '0, 1'b0);
    // Long hold on ch2 to saturate the narrow counter and reach SHUTDOWN.
    for (int c = 0; c < 40; c++) drive_cycle(4'b0100, '0, 1'b0);
    for (int c = 0; c < 4; c++) drive_cycle('0, '0, 1'b1);
    do_reset();

    for (int ph = 0; ph < 60; ph++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: begin
          ch = $urandom_range(0, N - 1);
          len = $urandom_range(4, 45);
          for (int c = 0; c < len; c++)
            drive_cycle(N'(1 << ch), '0, 1'($urandom_range(0, 7) == 0));
        end
        1, 2: begin
          hot = N'($urandom_range(1, 15));
          len = $urandom_range(10, 40);
          for (int c = 0; c < len; c++) begin
            for (int i = 0; i < N; i++) begin
              f[i] = hot[i] ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) == 0);
              m[i] = ($urandom_range(0, 7) == 0);
            end
            clr = ($urandom_range(0, 5) == 0);
            drive_cycle(f, m, clr);
          end
        end
        3: begin
          len = $urandom_range(6, 14);
          for (int c = 0; c < len; c++)
            drive_cycle('0, N'($urandom_range(0, 15)), 1'($urandom_range(0, 2) == 0));
        end
        default: begin
          do_reset();
        end
      endcase
    end

    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", 0, 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
